// File: rtl/seg7_scan_display_pkg.sv
// Shared types and helpers for the scanned 7-segment display path.
// Segment constants are active-high {dp,g,f,e,d,c,b,a}.
package seg7_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CONV,
      COMMIT
   } conv_state_t;

   localparam logic [7:0] SEG_BLANK = 8'h00;
   localparam logic [7:0] SEG_DASH  = 8'h40;

   // Digits 0-9 only; any other nibble decodes to an unlit digit.
   function automatic logic [6:0] seg_decode(input logic [3:0] nibble);
      logic [6:0] seg;
      case (nibble)
         4'd0:    seg = 7'h3F;
         4'd1:    seg = 7'h06;
         4'd2:    seg = 7'h5B;
         4'd3:    seg = 7'h4F;
         4'd4:    seg = 7'h66;
         4'd5:    seg = 7'h6D;
         4'd6:    seg = 7'h7D;
         4'd7:    seg = 7'h07;
         4'd8:    seg = 7'h7F;
         4'd9:    seg = 7'h6F;
         default: seg = SEG_BLANK[6:0];
      endcase
      return seg;
   endfunction

   function automatic logic [63:0] pow10(input int n);
      logic [63:0] p;
      p = 64'd1;
      for (int i = 0; i < n; i++) begin
         p = p * 64'd10;
      end
      return p;
   endfunction

endpackage

// File: rtl/seg7_scan_display_if.sv
// Ready/valid value port of the display: one transfer carries value, dp mask and blanking mode.
// The source (master) holds i_valid until o_ready; nothing is queued on the sink side.
interface seg7_scan_display_if #(
   parameter int N_DIGITS  = 4,
   parameter int BIN_WIDTH = 14
);
   logic                 i_valid;
   logic [BIN_WIDTH-1:0] i_value;
   logic [N_DIGITS-1:0]  i_dp;
   logic                 i_blankLZ;
   logic                 o_ready;

   modport master (
      output i_valid,
      output i_value,
      output i_dp,
      output i_blankLZ,
      input  o_ready
   );

   modport slave (
      input  i_valid,
      input  i_value,
      input  i_dp,
      input  i_blankLZ,
      output o_ready
   );
endinterface

// File: rtl/seg7_scan_display_bcd.sv
// Sequential double-dabble: accepts one value, BIN_WIDTH shift cycles, one commit cycle.
// Latency transfer edge + BIN_WIDTH+1; o_ready low for that whole span, accept period BIN_WIDTH+2.
module bin_to_bcd_seq
   import seg7_pkg::*;
#(
   parameter int BIN_WIDTH = 14,
   parameter int N_DIGITS  = 4
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   seg7_scan_display_if.slave      in_if,
   output logic                    o_commit,
   output logic [4*N_DIGITS-1:0]   o_bcd,
   output logic                    o_ovf,
   output logic [N_DIGITS-1:0]     o_dp,
   output logic                    o_blank
);

   localparam int          BCD_W   = 4 * N_DIGITS;
   localparam int          CNT_W   = $clog2(BIN_WIDTH + 1);
   localparam logic [63:0] MAX_VAL = pow10(N_DIGITS) - 64'd1;

   conv_state_t          state_q;
   logic                 ready_q;
   logic [BIN_WIDTH-1:0] shift_q, shift_d;
   logic [BCD_W-1:0]     bcd_q, bcd_d, bcd_adj;
   logic [CNT_W-1:0]     cnt_q;
   logic [N_DIGITS-1:0]  dp_q;
   logic                 blank_q;
   logic                 ovf_q;
   logic                 accept;

   assign accept = in_if.i_valid && ready_q;

   // Add-3 correction then shift; digits pushed past the top nibble are dropped.
   always_comb begin
      bcd_adj = bcd_q;
      for (int d = 0; d < N_DIGITS; d++) begin
         if (bcd_q[4*d +: 4] >= 4'd5) begin
            bcd_adj[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
         end
      end
      bcd_d   = {bcd_adj[BCD_W-2:0], shift_q[BIN_WIDTH-1]};
      shift_d = shift_q << 1;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= IDLE;
         ready_q <= 1'b1;
         shift_q <= '0;
         bcd_q   <= '0;
         cnt_q   <= '0;
         dp_q    <= '0;
         blank_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  state_q <= CONV;
                  ready_q <= 1'b0;
                  shift_q <= in_if.i_value;
                  bcd_q   <= '0;
                  cnt_q   <= '0;
                  dp_q    <= in_if.i_dp;
                  blank_q <= in_if.i_blankLZ;
                  ovf_q   <= (64'(in_if.i_value) > MAX_VAL);
               end
            end
            CONV: begin
               shift_q <= shift_d;
               bcd_q   <= bcd_d;
               cnt_q   <= cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(BIN_WIDTH - 1)) begin
                  state_q <= COMMIT;
               end
            end
            COMMIT: begin
               state_q <= IDLE;
               ready_q <= 1'b1;
            end
            default: begin
               state_q <= IDLE;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign in_if.o_ready = ready_q;
   assign o_commit      = (state_q == COMMIT);
   assign o_bcd         = bcd_q;
   assign o_ovf         = ovf_q;
   assign o_dp          = dp_q;
   assign o_blank       = blank_q;

endmodule

// File: rtl/seg7_scan_display.sv
// Scanned N-digit 7-segment driver: committed BCD is held and multiplexed one digit per SCAN_DIV clocks.
// Value port backpressures during conversion; select and segments are registered on the same edge.
module seg7_scan_display
   import seg7_pkg::*;
#(
   parameter int N_DIGITS   = 4,
   parameter int BIN_WIDTH  = 14,
   parameter int SCAN_DIV   = 50000,
   parameter int SEG_ACT_LO = 1,
   parameter int DIG_ACT_LO = 1
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   seg7_scan_display_if.slave   in_if,
   output logic                 o_overflow,
   output logic [N_DIGITS-1:0]  o_digitSelect,
   output logic [7:0]           o_LED
);

   localparam int                  BCD_W      = 4 * N_DIGITS;
   localparam int                  PRESC_W    = $clog2(SCAN_DIV);
   localparam int                  IDX_W      = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam logic [7:0]          LED_RST_HI = {1'b0, seg_decode(4'd0)};
   localparam logic [7:0]          LED_RST    = (SEG_ACT_LO != 0) ? ~LED_RST_HI : LED_RST_HI;
   localparam logic [N_DIGITS-1:0] SEL_RST_HI = N_DIGITS'(1);
   localparam logic [N_DIGITS-1:0] SEL_RST    = (DIG_ACT_LO != 0) ? ~SEL_RST_HI : SEL_RST_HI;

   logic                conv_commit;
   logic [BCD_W-1:0]    conv_bcd;
   logic                conv_ovf;
   logic [N_DIGITS-1:0] conv_dp;
   logic                conv_blank;

   logic [BCD_W-1:0]    disp_bcd_q;
   logic [N_DIGITS-1:0] disp_dp_q;
   logic                disp_blank_q;
   logic                disp_ovf_q;

   logic [PRESC_W-1:0]  presc_q, presc_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [N_DIGITS-1:0] sel_q, sel_d, sel_hi;
   logic [7:0]          led_q, led_d, seg_hi;
   logic [3:0]          nib;
   logic                upper_zero;

   bin_to_bcd_seq #(
      .BIN_WIDTH (BIN_WIDTH),
      .N_DIGITS  (N_DIGITS)
   ) u_conv (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .in_if    (in_if),
      .o_commit (conv_commit),
      .o_bcd    (conv_bcd),
      .o_ovf    (conv_ovf),
      .o_dp     (conv_dp),
      .o_blank  (conv_blank)
   );

   always_comb begin
      presc_d = presc_q + PRESC_W'(1);
      idx_d   = idx_q;
      if (presc_q == PRESC_W'(SCAN_DIV - 1)) begin
         presc_d = '0;
         idx_d   = (idx_q == IDX_W'(N_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
      end
   end

   // Decode for the digit selected next cycle so select and segments land together.
   always_comb begin
      nib        = disp_bcd_q[4*int'(idx_d) +: 4];
      upper_zero = ((disp_bcd_q >> (4 * int'(idx_d))) == '0);
      seg_hi     = {disp_dp_q[idx_d], seg_decode(nib)};
      if (disp_blank_q && (idx_d != '0) && upper_zero) begin
         seg_hi = {disp_dp_q[idx_d], SEG_BLANK[6:0]};
      end
      if (disp_ovf_q) begin
         seg_hi = SEG_DASH;
      end
      led_d  = (SEG_ACT_LO != 0) ? ~seg_hi : seg_hi;
      sel_hi = N_DIGITS'(1) << idx_d;
      sel_d  = (DIG_ACT_LO != 0) ? ~sel_hi : sel_hi;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         disp_bcd_q   <= '0;
         disp_dp_q    <= '0;
         disp_blank_q <= 1'b0;
         disp_ovf_q   <= 1'b0;
         presc_q      <= '0;
         idx_q        <= '0;
         sel_q        <= SEL_RST;
         led_q        <= LED_RST;
      end else begin
         if (conv_commit) begin
            disp_bcd_q   <= conv_bcd;
            disp_dp_q    <= conv_dp;
            disp_blank_q <= conv_blank;
            disp_ovf_q   <= conv_ovf;
         end
         presc_q <= presc_d;
         idx_q   <= idx_d;
         sel_q   <= sel_d;
         led_q   <= led_d;
      end
   end

   assign o_overflow    = disp_ovf_q;
   assign o_digitSelect = sel_q;
   assign o_LED         = led_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Directed bench for seg7_scan_display with a queue of expected panels popped after each commit.
module tb_seg7_scan_display;

   localparam int N   = 4;
   localparam int BW  = 14;
   localparam int DIV = 2;

   typedef struct packed {
      logic           ovf;
      logic [8*N-1:0] leds;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         ovf_o;
   logic [N-1:0] sel_o;
   logic [7:0]   led_o;

   int   checks = 0;
   int   errors = 0;
   int   low, hb, walk_bad, nrdy;
   exp_t sb[$];
   exp_t prev;

   seg7_scan_display_if #(.N_DIGITS(N), .BIN_WIDTH(BW)) bus ();

   seg7_scan_display #(
      .N_DIGITS   (N),
      .BIN_WIDTH  (BW),
      .SCAN_DIV   (DIV),
      .SEG_ACT_LO (1),
      .DIG_ACT_LO (1)
   ) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .in_if         (bus),
      .o_overflow    (ovf_o),
      .o_digitSelect (sel_o),
      .o_LED         (led_o)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [6:0] seg_of(input int d);
      case (d)
         0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
         4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
         8: return 7'h7F;  default: return 7'h6F;
      endcase
   endfunction

   function automatic exp_t model(input int unsigned v, input logic [N-1:0] dp, input bit blank);
      exp_t        e;
      int unsigned p, lim, higher;
      logic [6:0]  seg;
      lim = 1;
      for (int k = 0; k < N; k++) lim = lim * 10;
      e.ovf = (v >= lim);
      p = 1;
      for (int k = 0; k < N; k++) begin
         higher = v / p;
         seg    = seg_of(int'(higher % 10));
         if (blank && k != 0 && higher == 0) seg = 7'h00;
         e.leds[8*k +: 8] = e.ovf ? 8'h40 : {dp[k], seg};
         p = p * 10;
      end
      return e;
   endfunction

   function automatic int sel_idx(input logic [N-1:0] s);
      logic [N-1:0] hi;
      int           r;
      r  = -1;
      hi = ~s;
      if ($onehot(hi)) begin
         for (int k = 0; k < N; k++) if (hi[k]) r = k;
      end
      return r;
   endfunction

   task automatic send(input int unsigned v, input logic [N-1:0] dp, input bit blank);
      bus.i_value   = BW'(v);
      bus.i_dp      = dp;
      bus.i_blankLZ = blank;
      bus.i_valid   = 1'b1;
      sb.push_back(model(v, dp, blank));
      tick();
      bus.i_valid = 1'b0;
   endtask

   // Counts busy cycles and any lit digit that differs from the last committed panel.
   task automatic wait_ready(output int lo, output int held_bad);
      int k;
      lo       = 0;
      held_bad = 0;
      while (!bus.o_ready && lo < 100) begin
         lo++;
         k = sel_idx(sel_o);
         if (k >= 0 && ((~led_o !== prev.leds[8*k +: 8]) || (ovf_o !== prev.ovf))) held_bad++;
         tick();
      end
   endtask

   task automatic capture(input string tag);
      exp_t   e, got;
      logic [N-1:0] seen;
      int     bad_hot, k;
      got     = '0;
      seen    = '0;
      bad_hot = 0;
      for (int c = 0; c < 4 * N * DIV && seen != '1; c++) begin
         k = sel_idx(sel_o);
         if (k < 0) bad_hot++;
         else begin
            got.leds[8*k +: 8] = ~led_o;
            seen[k] = 1'b1;
         end
         if (seen != '1) tick();
      end
      got.ovf = ovf_o;
      check({tag, "_scan"}, 64'(seen), 64'({N{1'b1}}));
      check({tag, "_onehot"}, 64'(bad_hot), 64'd0);
      check({tag, "_pending"}, 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check({tag, "_panel"}, 64'(got.leds), 64'(e.leds));
         check({tag, "_ovf"}, 64'(got.ovf), 64'(e.ovf));
         prev = e;
      end
   endtask

   initial begin
      rst           = 1'b1;
      bus.i_valid   = 1'b0;
      bus.i_value   = '0;
      bus.i_dp      = '0;
      bus.i_blankLZ = 1'b0;
      prev          = model(0, '0, 1'b0);
      tick();
      tick();
      check("rst_ready", 64'(bus.o_ready), 64'd1);
      check("rst_ovf", 64'(ovf_o), 64'd0);
      check("rst_sel", 64'(sel_o), 64'hE);
      check("rst_led", 64'(led_o), 64'hC0);
      rst = 1'b0;

      walk_bad = 0;
      for (int i = 0; i < 4 * N * DIV; i++) begin
         if (sel_idx(sel_o) != (i / DIV) % N) walk_bad++;
         tick();
      end
      check("scan_walk", 64'(walk_bad), 64'd0);
      sb.push_back(model(0, '0, 1'b0));
      capture("idle_zero");
      check("idle_ready", 64'(bus.o_ready), 64'd1);

      send(1234, 4'b0000, 1'b0);
      check("accept_1234", 64'(bus.o_ready), 64'd0);
      wait_ready(low, hb);
      check("busy_1234", 64'(low), 64'(BW + 1));
      check("held_1234", 64'(hb), 64'd0);
      tick();
      capture("v1234");

      send(7, 4'b0100, 1'b1);
      wait_ready(low, hb);
      check("held_7", 64'(hb), 64'd0);
      tick();
      capture("v7_lz");

      send(10000, 4'b1111, 1'b0);
      wait_ready(low, hb);
      check("held_pre_ovf", 64'(hb), 64'd0);
      tick();
      capture("v10000");

      send(9999, 4'b0000, 1'b0);
      wait_ready(low, hb);
      tick();
      capture("v9999");

      // Valid stays high: second value must wait for the first commit.
      bus.i_value   = BW'(56);
      bus.i_dp      = 4'b0001;
      bus.i_blankLZ = 1'b1;
      bus.i_valid   = 1'b1;
      sb.push_back(model(56, 4'b0001, 1'b1));
      tick();
      check("b2b_acc1", 64'(bus.o_ready), 64'd0);
      bus.i_value   = BW'(8);
      bus.i_dp      = 4'b1000;
      bus.i_blankLZ = 1'b0;
      sb.push_back(model(8, 4'b1000, 1'b0));
      wait_ready(low, hb);
      check("b2b_busy1", 64'(low), 64'(BW + 1));
      tick();
      check("b2b_acc2", 64'(bus.o_ready), 64'd0);
      bus.i_valid = 1'b0;
      capture("b2b_first");
      wait_ready(low, hb);
      check("b2b_held", 64'(hb), 64'd0);
      tick();
      capture("b2b_second");

      bus.i_value   = BW'(4321);
      bus.i_dp      = 4'b0000;
      bus.i_blankLZ = 1'b0;
      bus.i_valid   = 1'b1;
      tick();
      bus.i_valid = 1'b0;
      repeat (5) tick();
      rst = 1'b1;
      #1;
      check("midrst_led", 64'(led_o), 64'hC0);
      check("midrst_sel", 64'(sel_o), 64'hE);
      check("midrst_ready", 64'(bus.o_ready), 64'd1);
      check("midrst_ovf", 64'(ovf_o), 64'd0);
      tick();
      rst = 1'b0;
      check("post_rst_ready", 64'(bus.o_ready), 64'd1);
      sb.delete();
      sb.push_back(model(0, '0, 1'b0));
      capture("post_rst");
      nrdy = 0;
      repeat (2 * BW) begin
         if (!bus.o_ready) nrdy++;
         tick();
      end
      check("post_rst_idle", 64'(nrdy), 64'd0);
      sb.push_back(model(0, '0, 1'b0));
      capture("no_4321");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
